// File: rtl/gfx256_wbs_ram_pkg.sv
// gfx256_wbs_ram_pkg: 256-bit Wishbone command request/response channel types
package gfx256_wbs_ram_pkg;
  typedef struct packed {
    logic         cyc;
    logic         stb;
    logic         we;
    logic [2:0]   cti;
    logic [1:0]   bte;
    logic [31:0]  sel;
    logic [31:0]  padr;
    logic [255:0] dat;
    logic [3:0]   cid;
    logic [7:0]   tid;
  } wb_cmd_request256_t;
  typedef struct packed {
    logic         ack;
    logic         err;
    logic         rty;
    logic         stall;
    logic         next;
    logic [255:0] dat;
    logic [3:0]   cid;
    logic [7:0]   tid;
  } wb_cmd_response256_t;
endpackage

// File: rtl/gfx256_wbs_ram.sv
// gfx256_wbs_ram: 256-bit Wishbone block-RAM responder (clk_i, rst_i, wbs_req in, registered wbs_resp out)
module gfx256_wbs_ram
  import gfx256_wbs_ram_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          LATENCY    = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  wb_cmd_request256_t  wbs_req,
  output wb_cmd_response256_t wbs_resp
);
  typedef enum logic [3:0] {IDLE = 4'b0001, BUSY = 4'b0010, RESP = 4'b0100, HOLD = 4'b1000} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic c_we, c_hit;
  logic [31:0] c_sel;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic [255:0] c_dat;
  logic [3:0] c_cid;
  logic [7:0] c_tid;
  logic [255:0] mem [2**DEPTH_LOG2];
  logic req, fire, unused_ok;
  assign req = wbs_req.cyc & wbs_req.stb;
  assign fire = state == BUSY && cnt == 4'd0 && !rst_i;
  assign unused_ok = ^{wbs_req.cti, wbs_req.bte, wbs_req.padr[4:0]};
  always_ff @(posedge clk_i) state <= rst_i ? IDLE : state_nx;
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE ? (req ? BUSY : IDLE) :
               state == BUSY ? (cnt == 4'd0 ? RESP : BUSY) :
               state == RESP ? HOLD :
               state == HOLD ? (req ? HOLD : IDLE) : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (state == IDLE && req) begin
      c_we  <= wbs_req.we;
      c_sel <= wbs_req.sel;
      c_idx <= wbs_req.padr[DEPTH_LOG2+4:5];
      c_dat <= wbs_req.dat;
      c_cid <= wbs_req.cid;
      c_tid <= wbs_req.tid;
      c_hit <= wbs_req.padr[31:DEPTH_LOG2+5] == BASE_ADDR[31:DEPTH_LOG2+5];
      cnt   <= 4'(LATENCY - 1);
    end else if (state == BUSY) cnt <= cnt - 4'd1;
  end
  always_ff @(posedge clk_i) begin
    if (fire && c_hit && c_we)
      for (int i = 0; i < 32; i++)
        if (c_sel[i]) mem[c_idx][8*i +: 8] <= c_dat[8*i +: 8];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) wbs_resp <= '0;
    else if (fire) begin
      wbs_resp.ack <= c_hit;
      wbs_resp.err <= !c_hit;
      wbs_resp.dat <= c_hit && !c_we ? mem[c_idx] : '0;
      wbs_resp.cid <= c_cid;
      wbs_resp.tid <= c_tid;
    end else begin
      wbs_resp.ack <= 1'b0;
      wbs_resp.err <= 1'b0;
      wbs_resp.dat <= '0;
    end
  end
endmodule

// File: tb/tb_gfx256_wbs_ram.sv
// tb_gfx256_wbs_ram: randomized self-checking bench for three latency builds of gfx256_wbs_ram
module tb_gfx256_wbs_ram;
  import gfx256_wbs_ram_pkg::*;
  localparam logic [31:0] BASE = 32'h0;
  localparam logic [31:0] WIN = 32'h8000;
  localparam logic [255:0] PAT = {4{64'h0123456789ABCDEF}};
  int lats [3] = '{2, 1, 15};
  logic clk, rst;
  wb_cmd_request256_t req [3];
  wb_cmd_response256_t resp [3];
  int checks = 0, errors = 0;
  bit run = 0;

  gfx256_wbs_ram #(.DEPTH_LOG2(10), .BASE_ADDR(BASE), .LATENCY(2))
    dut0 (.clk_i(clk), .rst_i(rst), .wbs_req(req[0]), .wbs_resp(resp[0]));
  gfx256_wbs_ram #(.DEPTH_LOG2(10), .BASE_ADDR(BASE), .LATENCY(1))
    dut1 (.clk_i(clk), .rst_i(rst), .wbs_req(req[1]), .wbs_resp(resp[1]));
  gfx256_wbs_ram #(.DEPTH_LOG2(10), .BASE_ADDR(BASE), .LATENCY(15))
    dut2 (.clk_i(clk), .rst_i(rst), .wbs_req(req[2]), .wbs_resp(resp[2]));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, expv);
    end
  endtask

  // Reference model: a request accepted at edge n is answered at edge n+latency,
  // the answer lasts one cycle, and the responder is free again the edge after it
  // sees the strobe low, no earlier than two edges past the answer.
  logic [255:0] mm [int];
  wb_cmd_response256_t exp_r [3];
  wb_cmd_request256_t cmd [3];
  bit busy [3], dat_known [3], zero_all [3];
  int t_ack [3];
  int cyc_n = 0;
  int key;
  logic [255:0] w;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      zero_all[k] = 1'b0;
      if (rst) begin
        busy[k] = 1'b0;
        exp_r[k] = '0;
        zero_all[k] = 1'b1;
        dat_known[k] = 1'b1;
      end else if (!busy[k]) begin
        if (req[k].cyc && req[k].stb) begin
          busy[k] = 1'b1;
          t_ack[k] = cyc_n + lats[k];
          cmd[k] = req[k];
        end
      end else if (cyc_n == t_ack[k]) begin
        exp_r[k].cid = cmd[k].cid;
        exp_r[k].tid = cmd[k].tid;
        dat_known[k] = 1'b1;
        if (cmd[k].padr >= BASE && cmd[k].padr - BASE < WIN) begin
          key = k * 65536 + int'((cmd[k].padr - BASE) / 32);
          exp_r[k].ack = 1'b1;
          exp_r[k].err = 1'b0;
          if (cmd[k].we) begin
            exp_r[k].dat = '0;
            if (mm.exists(key)) begin
              w = mm[key];
              for (int i = 0; i < 32; i++)
                if (cmd[k].sel[i]) w[8*i +: 8] = cmd[k].dat[8*i +: 8];
              mm[key] = w;
            end else if (cmd[k].sel == 32'hFFFF_FFFF) mm[key] = cmd[k].dat;
          end else begin
            dat_known[k] = mm.exists(key);
            exp_r[k].dat = mm.exists(key) ? mm[key] : '0;
          end
        end else begin
          exp_r[k].ack = 1'b0;
          exp_r[k].err = 1'b1;
          exp_r[k].dat = '0;
        end
      end else if (cyc_n > t_ack[k]) begin
        exp_r[k].ack = 1'b0;
        exp_r[k].err = 1'b0;
        exp_r[k].dat = '0;
        if (cyc_n >= t_ack[k] + 2 && !(req[k].cyc && req[k].stb)) busy[k] = 1'b0;
      end
    end
    cyc_n++;
  end

  always @(negedge clk) begin
    if (run)
      for (int k = 0; k < 3; k++) begin
        if (zero_all[k]) check($sformatf("reset_outputs_ch%0d", k), 512'(resp[k]), '0);
        else begin
          check($sformatf("ack_ch%0d", k), 512'(resp[k].ack), 512'(exp_r[k].ack));
          check($sformatf("err_ch%0d", k), 512'(resp[k].err), 512'(exp_r[k].err));
          check($sformatf("rty_ch%0d", k), 512'(resp[k].rty), '0);
          if (dat_known[k]) check($sformatf("dat_ch%0d", k), 512'(resp[k].dat), 512'(exp_r[k].dat));
          if (exp_r[k].ack || exp_r[k].err) begin
            check($sformatf("cid_ch%0d", k), 512'(resp[k].cid), 512'(exp_r[k].cid));
            check($sformatf("tid_ch%0d", k), 512'(resp[k].tid), 512'(exp_r[k].tid));
          end
        end
      end
  end

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic txn(input int k, input bit we, input logic [31:0] sel, input logic [31:0] padr,
                     input logic [255:0] dat, input int hold,
                     output wb_cmd_response256_t r, output int lat, output int acks);
    bit got;
    logic [7:0] tid0;
    @(negedge clk);
    req[k] = '0;
    req[k].cyc = 1'b1;
    req[k].stb = 1'b1;
    req[k].we = we;
    req[k].sel = sel;
    req[k].padr = padr;
    req[k].dat = dat;
    req[k].cid = 4'($urandom);
    req[k].tid = 8'($urandom);
    req[k].cti = 3'($urandom);
    req[k].bte = 2'($urandom);
    tid0 = req[k].tid;
    got = 1'b0;
    lat = 0;
    acks = 0;
    r = '0;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (resp[k].ack || resp[k].err) begin
        got = 1'b1;
        r = resp[k];
      end else begin
        req[k].dat = rnd256();
        req[k].sel = $urandom;
        req[k].padr = $urandom;
        req[k].we = 1'($urandom);
        req[k].cid = 4'($urandom);
        req[k].tid = 8'($urandom);
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout ch%0d got no ack/err in %0d cycles want one", k, lat);
    end else check($sformatf("tid_echo_ch%0d", k), 512'(r.tid), 512'(tid0));
    acks = int'(r.ack) + int'(r.err);
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      acks += int'(resp[k].ack) + int'(resp[k].err);
    end
    if ($urandom_range(0, 1) == 1) req[k].cyc = 1'b0;
    else req[k].stb = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic rand_phase(input int k, input int nw, input int n);
    wb_cmd_response256_t r;
    int lat, acks, m;
    logic [31:0] sel, pa;
    for (int t = 0; t < n; t++) begin
      m = $urandom_range(0, 9);
      sel = m == 0 ? 32'h0 : m == 1 ? 32'hFFFF_FFFF : $urandom;
      pa = $urandom_range(0, 7) == 0 ? ($urandom | WIN) :
           BASE + (32'($urandom_range(0, nw - 1)) << 5) + 32'($urandom_range(0, 31));
      txn(k, 1'($urandom), sel, pa, rnd256(), $urandom_range(0, 2), r, lat, acks);
      check($sformatf("latency_ch%0d", k), 512'(lat), 512'(lats[k] + 1));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  task automatic preload(input int k, input int nw, output logic [255:0] w0);
    wb_cmd_response256_t r;
    int lat, acks;
    logic [255:0] d;
    for (int i = 0; i < nw; i++) begin
      d = i == 5 ? {32{8'hAA}} : i == 7 ? 256'h0 : rnd256();
      if (i == 0) w0 = d;
      txn(k, 1'b1, 32'hFFFF_FFFF, BASE + 32'(i * 32), d, 0, r, lat, acks);
    end
  endtask

  initial begin
    wb_cmd_response256_t r;
    int lat, acks;
    logic [255:0] w0, d;
    for (int k = 0; k < 3; k++) req[k] = '0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_resp_ch0", 512'(resp[0]), '0);
    preload(0, 16, w0);
    txn(0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0040, PAT, 0, r, lat, acks);
    check("write_latency", 512'(lat), 512'(3));
    check("write_ack", 512'(r.ack), 512'(1));
    check("write_dat_zero", 512'(r.dat), '0);
    txn(0, 1'b0, 32'h0, 32'h0000_0040, rnd256(), 0, r, lat, acks);
    check("read_latency", 512'(lat), 512'(3));
    check("read_pattern", 512'(r.dat), 512'(PAT));
    d = rnd256();
    d[31:0] = 32'h1122_3344;
    txn(0, 1'b1, 32'h0000_000F, 32'h0000_00A0, d, 0, r, lat, acks);
    txn(0, 1'b0, 32'h0, 32'h0000_00A0, rnd256(), 0, r, lat, acks);
    check("byte_lanes", 512'(r.dat), 512'({{28{8'hAA}}, 32'h1122_3344}));
    txn(0, 1'b0, 32'hFFFF_FFFF, 32'h0000_8000, rnd256(), 0, r, lat, acks);
    check("miss_err", 512'(r.err), 512'(1));
    check("miss_ack", 512'(r.ack), '0);
    check("miss_dat", 512'(r.dat), '0);
    txn(0, 1'b1, 32'hFFFF_FFFF, 32'h0000_8000, rnd256(), 0, r, lat, acks);
    check("miss_write_err", 512'(r.err), 512'(1));
    txn(0, 1'b0, 32'h0, 32'h0000_0000, rnd256(), 0, r, lat, acks);
    check("miss_no_write", 512'(r.dat), 512'(w0));
    txn(0, 1'b0, 32'h0, 32'h0000_0040, rnd256(), 2, r, lat, acks);
    check("held_single_ack", 512'(acks), 512'(1));
    txn(0, 1'b0, 32'h0, 32'h0000_0040, rnd256(), 0, r, lat, acks);
    check("after_hold_latency", 512'(lat), 512'(3));
    check("after_hold_data", 512'(r.dat), 512'(PAT));
    @(negedge clk);
    req[0] = '0;
    req[0].cyc = 1'b1;
    req[0].stb = 1'b1;
    req[0].we = 1'b1;
    req[0].sel = 32'hFFFF_FFFF;
    req[0].padr = 32'h0000_00E0;
    req[0].dat = {32{8'h55}};
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_mid_write_outputs", 512'(resp[0]), '0);
    rst = 1'b0;
    req[0] = '0;
    repeat (2) @(posedge clk);
    txn(0, 1'b0, 32'h0, 32'h0000_00E0, rnd256(), 0, r, lat, acks);
    check("reset_mid_write_word7", 512'(r.dat), '0);
    rand_phase(0, 16, 60);
    preload(1, 8, w0);
    txn(1, 1'b0, 32'h0, 32'h0, rnd256(), 0, r, lat, acks);
    check("lat1_latency", 512'(lat), 512'(2));
    check("lat1_word0", 512'(r.dat), 512'(w0));
    rand_phase(1, 8, 30);
    preload(2, 4, w0);
    txn(2, 1'b0, 32'h0, 32'h0, rnd256(), 0, r, lat, acks);
    check("lat15_latency", 512'(lat), 512'(16));
    check("lat15_word0", 512'(r.dat), 512'(w0));
    rand_phase(2, 4, 8);
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
